// File: rtl/ram_ctrl.sv
// Command sequencer for the 32x3 ram block: single read/write, whole-array clear,
// one response per command, read timing matched to the ram's two-register read path.
module ram_ctrl #(
  parameter int AW = 5,
  parameter int DW = 3
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cmd_valid,
  output logic          cmd_ready,
  input  logic [1:0]    cmd_op,
  input  logic [AW-1:0] cmd_addr,
  input  logic [DW-1:0] cmd_data,
  output logic          rsp_valid,
  output logic [DW-1:0] rsp_data,
  output logic          rsp_err,
  output logic          busy,
  output logic [AW-1:0] ram_addr,
  output logic [DW-1:0] ram_din,
  output logic          ram_write,
  input  logic [DW-1:0] ram_dout
);

  typedef enum logic [2:0] {IDLE, WR, RD1, RD2, RD3, CLR, ERR} state_t;

  localparam logic [AW-1:0] LAST_ADDR = '1;

  state_t state;

  assign cmd_ready = (state == IDLE);
  assign busy      = ~cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ram_addr  <= '0;
      ram_din   <= '0;
      ram_write <= 1'b0;
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
    end else begin
      // Response flags pulse for one cycle; rsp_data holds between responses.
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            case (cmd_op)
              2'b00: begin
                ram_addr  <= cmd_addr;
                ram_write <= 1'b0;
                state     <= RD1;
              end
              2'b01: begin
                ram_addr  <= cmd_addr;
                ram_din   <= cmd_data;
                ram_write <= 1'b1;
                rsp_valid <= 1'b1;
                rsp_data  <= cmd_data;
                state     <= WR;
              end
              2'b10: begin
                ram_addr  <= '0;
                ram_din   <= '0;
                ram_write <= 1'b1;
                state     <= CLR;
              end
              default: begin
                ram_write <= 1'b0;
                rsp_valid <= 1'b1;
                rsp_err   <= 1'b1;
                rsp_data  <= '0;
                state     <= ERR;
              end
            endcase
          end
        end
        WR: begin
          ram_write <= 1'b0;
          state     <= IDLE;
        end
        RD1: state <= RD2;
        RD2: state <= RD3;
        // The ram's output register has settled on the addressed word by now.
        RD3: begin
          rsp_data  <= ram_dout;
          rsp_valid <= 1'b1;
          state     <= IDLE;
        end
        CLR: begin
          if (ram_addr == LAST_ADDR) begin
            ram_write <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_data  <= '0;
            state     <= IDLE;
          end else begin
            ram_addr <= ram_addr + AW'(1);
          end
        end
        ERR: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// Scoreboard bench for ram_ctrl with a behavioural model of the two-register ram.
module tb_ram_ctrl;

  typedef struct {
    logic [2:0] data;
    logic       err;
    logic       dc;
    int         exp_cyc;
  } exp_t;

  logic       clk;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [4:0] cmd_addr;
  logic [2:0] cmd_data;
  logic       rsp_valid;
  logic [2:0] rsp_data;
  logic       rsp_err;
  logic       busy;
  logic [4:0] ram_addr;
  logic [2:0] ram_din;
  logic       ram_write;
  logic [2:0] ram_dout;

  logic [2:0] mem [32];
  logic [4:0] m_addr;
  logic [2:0] m_din;
  logic       m_we;

  exp_t q[$];
  exp_t e;
  int   cyc = 0;
  int   acc_count = 0;
  int   acc_cyc = 0;
  int   errors = 0;
  int   checks = 0;
  int   clr_writes = 0;
  int   nowr_count = 0;
  int   r_acc;
  logic in_clear = 1'b0;
  logic watch_nowr = 1'b0;

  logic [2:0] pend_data;
  logic       pend_err;
  logic       pend_dc;
  int         pend_lat;

  ram_ctrl #(.AW(5), .DW(3)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_err(rsp_err), .busy(busy),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_write(ram_write), .ram_dout(ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // ram: inputs registered, write commits and DataOut updates one edge later; no reset.
  always @(posedge clk) begin
    m_addr <= ram_addr;
    m_din  <= ram_din;
    m_we   <= ram_write;
    if (m_we === 1'b1) mem[m_addr] <= m_din;
    ram_dout <= mem[m_addr];
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(posedge clk) begin
    if (rst_n && cmd_valid && cmd_ready) begin
      q.push_back('{data: pend_data, err: pend_err, dc: pend_dc, exp_cyc: cyc + 1 + pend_lat});
      acc_cyc = cyc + 1;
      acc_count++;
    end
  end

  // Monitor: pops the scoreboard whenever a response appears, flags late or stray ones.
  always @(negedge clk) begin
    if (rst_n) begin
      if (in_clear && ram_write) begin
        checkOutput("clr_addr_order", int'(ram_addr), clr_writes);
        clr_writes++;
      end
      if (watch_nowr && ram_write) nowr_count++;
      if (rsp_valid) begin
        if (q.size() == 0) begin
          checkOutput("unexpected_rsp", 1, 0);
        end else begin
          e = q.pop_front();
          checkOutput("rsp_cycle", cyc, e.exp_cyc);
          if (!e.dc) checkOutput("rsp_data", int'(rsp_data), int'(e.data));
          checkOutput("rsp_err", int'(rsp_err), int'(e.err));
        end
      end else if (q.size() > 0 && cyc > q[0].exp_cyc) begin
        checkOutput("missing_rsp", cyc, q[0].exp_cyc);
        void'(q.pop_front());
      end
    end
  end

  task automatic applyStimulus(input logic [1:0] op, input logic [4:0] addr, input logic [2:0] data,
                               input logic [2:0] exp_data, input logic exp_err, input logic dc,
                               input int lat);
    int start;
    pend_data = exp_data;
    pend_err  = exp_err;
    pend_dc   = dc;
    pend_lat  = lat;
    cmd_op    = op;
    cmd_addr  = addr;
    cmd_data  = data;
    cmd_valid = 1'b1;
    start     = acc_count;
    for (int n = 0; n < 200 && acc_count == start; n++) @(negedge clk);
    if (acc_count == start) checkOutput("accept_timeout", 0, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic waitDrain();
    for (int n = 0; n < 300 && q.size() != 0; n++) @(negedge clk);
    checkOutput("drain_pending", q.size(), 0);
    q.delete();
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_cmd_ready"}, int'(cmd_ready), 1);
    checkOutput({tag, "_busy"}, int'(busy), 0);
    checkOutput({tag, "_ram_addr"}, int'(ram_addr), 0);
    checkOutput({tag, "_ram_din"}, int'(ram_din), 0);
    checkOutput({tag, "_ram_write"}, int'(ram_write), 0);
    checkOutput({tag, "_rsp_valid"}, int'(rsp_valid), 0);
    checkOutput({tag, "_rsp_data"}, int'(rsp_data), 0);
    checkOutput({tag, "_rsp_err"}, int'(rsp_err), 0);
  endtask

  function automatic logic [2:0] pat(input int i);
    return 3'((i % 7) + 1);
  endfunction

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    cmd_op = 2'b00;
    cmd_addr = '0;
    cmd_data = '0;
    #1 rst_n = 1'b0;
    #1 checkResetValues("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] write then read addr 5");
    applyStimulus(2'b01, 5'd5, 3'b101, 3'b101, 1'b0, 1'b0, 0);
    applyStimulus(2'b00, 5'd5, 3'b000, 3'b101, 1'b0, 1'b0, 3);
    waitDrain();

    $display("[TB] asynchronous reset during a read");
    applyStimulus(2'b01, 5'd6, 3'b011, 3'b011, 1'b0, 1'b0, 0);
    applyStimulus(2'b00, 5'd6, 3'b000, 3'b011, 1'b0, 1'b0, 3);
    checkOutput("busy_in_read", int'(busy), 1);
    #3 rst_n = 1'b0;
    #1 q.delete();
    checkResetValues("mid");
    @(negedge clk) rst_n = 1'b1;
    @(negedge clk) checkOutput("ready_after_release", int'(cmd_ready), 1);

    $display("[TB] boundary addresses");
    applyStimulus(2'b01, 5'd0, 3'b001, 3'b001, 1'b0, 1'b0, 0);
    applyStimulus(2'b01, 5'd31, 3'b110, 3'b110, 1'b0, 1'b0, 0);
    applyStimulus(2'b00, 5'd31, 3'b000, 3'b110, 1'b0, 1'b0, 3);
    applyStimulus(2'b00, 5'd0, 3'b000, 3'b001, 1'b0, 1'b0, 3);
    waitDrain();

    $display("[TB] fill, clear, read back");
    for (int i = 0; i < 32; i++) applyStimulus(2'b01, 5'(i), 3'b111, 3'b111, 1'b0, 1'b0, 0);
    @(negedge clk);
    clr_writes = 0;
    in_clear = 1'b1;
    applyStimulus(2'b10, 5'd0, 3'b000, 3'b000, 1'b0, 1'b0, 32);
    waitDrain();
    in_clear = 1'b0;
    checkOutput("clr_write_count", clr_writes, 32);
    for (int i = 31; i >= 0; i--) applyStimulus(2'b00, 5'(i), 3'b000, 3'b000, 1'b0, 1'b0, 3);
    waitDrain();

    $display("[TB] reserved op held behind a read");
    nowr_count = 0;
    watch_nowr = 1'b1;
    applyStimulus(2'b00, 5'd7, 3'b000, 3'b000, 1'b0, 1'b0, 3);
    r_acc = acc_cyc;
    applyStimulus(2'b11, 5'd9, 3'b101, 3'b000, 1'b1, 1'b0, 0);
    checkOutput("reserved_accept_gap", acc_cyc - r_acc, 4);
    waitDrain();
    watch_nowr = 1'b0;
    checkOutput("reserved_no_write", nowr_count, 0);

    $display("[TB] reset during clear");
    for (int i = 0; i < 32; i++) applyStimulus(2'b01, 5'(i), pat(i), pat(i), 1'b0, 1'b0, 0);
    waitDrain();
    applyStimulus(2'b10, 5'd0, 3'b000, 3'b000, 1'b0, 1'b0, 32);
    repeat (10) @(negedge clk);
    checkOutput("clr_addr_at_abort", int'(ram_addr), 10);
    #2 rst_n = 1'b0;
    #1 q.delete();
    checkOutput("abort_ram_write", int'(ram_write), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(negedge clk);
    for (int i = 0; i < 32; i++)
      applyStimulus(2'b00, 5'(i), 3'b000, (i < 9) ? 3'b000 : pat(i), 1'b0, (i == 9), 3);
    waitDrain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
